doodle_sprite_loader: RTL

Bus-side writer for the Doodle sprite RAM. It takes 32-bit words from the processor over a valid/ready stream, unpacks each word into sixteen 2-bit palette codes, and drives the sprite source's RAM write port (`we`, `addr_w`, `pixel_in`) at one pixel per clock. It sits between the MMIO/DMA slot and the doodle sprite core, so sprite frames are loaded at run time instead of from a ROM image.

---
 rtl/doodle_pkg.sv | 28 ++
 rtl/doodle_sprite_loader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/doodle_pkg.sv
// doodle_pkg
// Shared definitions for the Doodle sprite blocks.
//   loader_state_t : sprite RAM loader FSM states
//   PLT_*          : 2-bit palette codes shared by the loader and the sprite core palette
//   ppw_of()/PPW   : pixels carried by one packed input word (two bits per pixel)
package doodle_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } loader_state_t;

    localparam logic [1:0] PLT_KEY   = 2'b00;
    localparam logic [1:0] PLT_GRAY  = 2'b01;
    localparam logic [1:0] PLT_BODY  = 2'b10;
    localparam logic [1:0] PLT_WHITE = 2'b11;

    // Pixels per packed word: each palette code occupies two bits.
    function automatic int unsigned ppw_of(input int unsigned word_w);
        return word_w / 32'd2;
    endfunction

    localparam int unsigned LOADER_WORD_DEFAULT = 32'd32;
    localparam int unsigned PPW = ppw_of(LOADER_WORD_DEFAULT);

endpackage

// File: rtl/doodle_sprite_loader.sv
// doodle_sprite_loader
// Bus-side writer for the Doodle sprite RAM. Accepts packed words on a
// valid/ready stream, unpacks each into WORD/2 two-bit palette codes
// (pixel 0 in bits [1:0]) and writes them one per clock to consecutive
// sprite RAM addresses starting at base_addr (wrapping modulo 2^ADDR).
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   start      one-cycle load request, honoured only in IDLE
//   abort      cancels the load in progress (next state IDLE, no done)
//   base_addr  first pixel address, sampled with start
//   num_words  number of words to load, sampled with start (0 = empty load)
//   s_valid    input word valid
//   s_data     packed pixels, LSB-first
//   s_ready    loader accepts a word (never depends on s_valid)
//   we         sprite RAM write enable
//   addr_w     sprite RAM write address
//   pixel_out  palette code for the sprite RAM pixel_in port
//   busy       high whenever not IDLE
//   done       one-cycle pulse when a load completes
module doodle_sprite_loader
    import doodle_pkg::*;
#(
    parameter int ADDR = 10,
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [ADDR-1:0] base_addr,
    input  logic [ADDR-4:0] num_words,
    input  logic            s_valid,
    input  logic [WORD-1:0] s_data,
    output logic            s_ready,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [1:0]      pixel_out,
    output logic            busy,
    output logic            done
);

    localparam int unsigned PIX_PER_WORD = ppw_of(WORD);
    localparam int          PIX_W        = $clog2(PIX_PER_WORD);
    localparam int          NW           = ADDR - 3;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_PER_WORD - 1);

    loader_state_t   state_r;
    logic [ADDR-1:0] addr_r;
    logic [WORD-1:0] sh_r;
    logic [PIX_W-1:0] pix_idx_r;
    logic [NW-1:0]   words_left_r;

    logic last_pix_s;
    logic more_s;
    logic hs_s;

    assign last_pix_s = (pix_idx_r == LAST_PIX);
    assign more_s     = (words_left_r > NW'(1));
    assign hs_s       = s_valid && s_ready;

    // The write port is driven straight from the address and shift registers.
    assign addr_w    = addr_r;
    assign pixel_out = sh_r[1:0];

    // Moore decode of the registered state into the handshake and status outputs.
    always_comb begin
        s_ready = 1'b0;
        we      = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            WAIT_WORD: begin
                s_ready = 1'b1;
            end
            SHIFT: begin
                we = 1'b1;
                // Offer the next word only on the final pixel, and only if
                // another word is still owed; this is what makes loads gapless.
                if (last_pix_s && more_s) begin
                    s_ready = 1'b1;
                end else begin
                    s_ready = 1'b0;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Loader FSM with its address, shift and word counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            sh_r         <= '0;
            pix_idx_r    <= '0;
            words_left_r <= '0;
        end else if (abort) begin
            // Any partially shifted word is dropped; the write already on the
            // port this cycle still lands because we is a decode of SHIFT.
            state_r   <= IDLE;
            sh_r      <= '0;
            pix_idx_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        addr_r       <= base_addr;
                        words_left_r <= num_words;
                        if (num_words == '0) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= WAIT_WORD;
                        end
                    end
                end
                WAIT_WORD: begin
                    if (hs_s) begin
                        sh_r      <= s_data;
                        pix_idx_r <= '0;
                        state_r   <= SHIFT;
                    end
                end
                SHIFT: begin
                    addr_r    <= addr_r + ADDR'(1);
                    pix_idx_r <= pix_idx_r + PIX_W'(1);
                    if (last_pix_s) begin
                        words_left_r <= words_left_r - NW'(1);
                        if (!more_s) begin
                            sh_r    <= {2'b00, sh_r[WORD-1:2]};
                            state_r <= DONE;
                        end else if (hs_s) begin
                            sh_r      <= s_data;
                            pix_idx_r <= '0;
                        end else begin
                            sh_r    <= {2'b00, sh_r[WORD-1:2]};
                            state_r <= WAIT_WORD;
                        end
                    end else begin
                        sh_r <= {2'b00, sh_r[WORD-1:2]};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
